hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  In-order scoreboard between the decode stage and execute. Tracks every issued instruction that writes the
//  register file until writeback, and withholds issue while a source register has a pending write.
//  Flush drops only entries not yet committed past the flush point. Drives the decode stage's next-ready input.
// PARAMETERS
//  REGNO      8  number of architectural registers (width of write-enable/source masks)
//  REGNO_LOG  3  register index width
//  DEPTH      4  max in-flight tracked instructions; power of two, >=2
// PORTS
//  i_clk          in   1          clock, all state on rising edge
//  i_rst_n        in   1          asynchronous active-low reset
//  i_issue        in   1          decode submits one instruction this cycle
//  i_issue_rf_ie  in   REGNO      one-hot (or zero) destination write-enable of issuing instr
//  i_issue_src    in   REGNO      mask of source registers read by issuing instr
//  o_issue_ok     out  1          combinational: instr presented now may issue
//  i_commit       in   1          oldest uncommitted entry passed the flush point (execute done)
//  i_flush        in   1          discard all uncommitted entries
//  i_wb_valid     in   1          oldest committed entry wrote back; retire it
//  o_pending_mask out  REGNO      registered OR of destinations of all valid entries
//  o_count        out  log2(DEPTH)+1  registered number of valid entries
//  o_full         out  1          registered, o_count==DEPTH
//  o_err          out  1          sticky protocol error (commit/wb with nothing eligible)
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): head/commit/tail pointers 0, all entries invalid, o_pending_mask 0,
//    o_count 0, o_full 0, o_err 0. Reset mid-operation discards all entries immediately.
//  - Storage: DEPTH-entry circular buffer of REGNO-bit dest masks; pointers head<=cmt<=tail (mod, with wrap bit).
//    Entries [head,cmt) committed; [cmt,tail) issued/uncommitted.
//  - Every issued instr allocates an entry, even with i_issue_rf_ie==0 (keeps commit/wb order 1:1).
//  - o_issue_ok = ~o_full_eff & ~|(i_issue_src & pend_eff); pend_eff = OR of valid entries excluding the head
//    entry when i_wb_valid is high this cycle (same-cycle writeback release); o_full_eff likewise counts
//    a same-cycle retire as freeing a slot. Pure comb, no dependence on i_issue (no loop).
//  - i_issue with o_issue_ok=0 is ignored (no allocation) and sets o_err.
//  - Issue latency: entry visible in o_pending_mask/o_count the cycle after i_issue.
//  - i_commit: cmt<=cmt+1; if cmt==tail (none uncommitted, and no same-cycle issue) ignore, set o_err.
//  - i_wb_valid: head<=head+1; if head==cmt (none committed) ignore, set o_err.
//  - i_flush: tail<=cmt (after applying same-cycle i_commit); same-cycle i_issue is dropped. Committed
//    entries survive and still retire via i_wb_valid.
//  - Simultaneous issue+commit+wb: all three apply; count = count+issue-wb. Commit may target the entry
//    issued the same cycle only if none older uncommitted exists -> not allowed, treat as o_err.
//  - Wrap: pointers carry an extra MSB; full when MSBs differ and indices match.
//  - o_pending_mask, o_count, o_full recomputed from next-state and registered.
// STRUCTURE
//  - Shared package/config include: REGNO, REGNO_LOG (already global), pointer width macro.
//  - One sub-module natural: sb_ptr (wrapping pointer with MSB, inc enable, load for flush).
//  - Pending-mask OR-reduction and hazard compare inline in hazard_scoreboard.
// TESTING
//  - Reset: drive i_rst_n=0 mid-stream with 3 entries -> next sampling o_count=0, o_pending_mask=0, o_issue_ok=1.
//  - RAW: issue rf_ie=8'h04; next cycle src=8'h04 -> o_issue_ok=0 until i_commit then i_wb_valid; ok=1 in wb cycle.
//  - Full: 4 issues with rf_ie=0 -> o_full=1, o_count=4, o_issue_ok=0; i_wb_valid after commits frees same cycle.
//  - Flush: issue r1,r2,r3, commit once, flush -> o_count=1, o_pending_mask=8'h02; wb -> empty.
//  - Simultaneous: count=2 (1 committed), issue+commit+wb in one cycle -> o_count=2, no o_err.
//  - Protocol: i_wb_valid when empty -> o_err=1, pointers unchanged; 10-cycle wrap run keeps counts consistent.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared configuration for the decode/execute hazard scoreboard.
// Register-file geometry and tracking depth defaults plus pointer-width helper.
package hazard_scoreboard_pkg;

    localparam int unsigned SB_REGNO_LOG = 3;
    localparam int unsigned SB_REGNO     = 1 << SB_REGNO_LOG;
    localparam int unsigned SB_DEPTH     = 4;

    // Index bits plus one wrap bit so full and empty are distinguishable.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_ptr.sv
// Wrapping circular-buffer pointer with wrap MSB; increments on enable, loads on flush.
// Exposes its next value so the owner can register state derived from it.
module hazard_scoreboard_sb_ptr #(
    parameter int unsigned W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_ptr,
    output logic [W-1:0] o_ptr_nxt_c
);

    always_comb begin
        o_ptr_nxt_c = o_ptr;
        if (i_load) begin
            o_ptr_nxt_c = i_load_val;
        end else if (i_inc) begin
            o_ptr_nxt_c = o_ptr + W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ptr <= '0;
        end else begin
            o_ptr <= o_ptr_nxt_c;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order register write scoreboard between decode and execute.
// Holds issue while a source register has a pending write; flush drops only uncommitted entries.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REGNO = SB_REGNO,
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_issue,
    input  logic [REGNO-1:0]   i_issue_rf_ie,
    input  logic [REGNO-1:0]   i_issue_src,
    output logic               o_issue_ok,
    input  logic               i_commit,
    input  logic               i_flush,
    input  logic               i_wb_valid,
    output logic [REGNO-1:0]   o_pending_mask,
    output logic [ptr_w(DEPTH)-1:0] o_count,
    output logic               o_full,
    output logic               o_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = ptr_w(DEPTH);

    logic [PTR_W-1:0] head, cmt, tail;
    logic [PTR_W-1:0] head_nxt, cmt_nxt, tail_nxt;
    logic [PTR_W-1:0] count_c, count_nxt;
    logic [REGNO-1:0] dest_q [DEPTH];
    logic [REGNO-1:0] pend_eff, pend_nxt;
    logic             wb_ok, cmt_ok, issue_acc, full_eff, full_nxt, err_set;

    assign count_c = tail - head;
    assign wb_ok   = i_wb_valid & (head != cmt);
    assign cmt_ok  = i_commit & (cmt != tail);

    // Hazard view: the entry retiring this cycle no longer blocks a reader.
    always_comb begin
        logic [IDX_W-1:0] off;
        pend_eff = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = IDX_W'(i) - head[IDX_W-1:0];
            if ((PTR_W'(off) < count_c) && !(wb_ok && (off == '0))) begin
                pend_eff = pend_eff | dest_q[i];
            end
        end
    end

    assign full_eff   = (count_c == PTR_W'(DEPTH)) & ~wb_ok;
    assign o_issue_ok = ~full_eff & ~|(i_issue_src & pend_eff);
    assign issue_acc  = i_issue & o_issue_ok & ~i_flush;
    assign err_set    = (i_issue & ~o_issue_ok) | (i_commit & ~cmt_ok) | (i_wb_valid & ~wb_ok);

    hazard_scoreboard_sb_ptr #(.W(PTR_W)) u_head (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_inc       (wb_ok),
        .i_load      (1'b0),
        .i_load_val  ('0),
        .o_ptr       (head),
        .o_ptr_nxt_c (head_nxt)
    );

    hazard_scoreboard_sb_ptr #(.W(PTR_W)) u_cmt (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_inc       (cmt_ok),
        .i_load      (1'b0),
        .i_load_val  ('0),
        .o_ptr       (cmt),
        .o_ptr_nxt_c (cmt_nxt)
    );

    // Flush rewinds tail to the commit point after this cycle's commit.
    hazard_scoreboard_sb_ptr #(.W(PTR_W)) u_tail (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_inc       (issue_acc),
        .i_load      (i_flush),
        .i_load_val  (cmt_nxt),
        .o_ptr       (tail),
        .o_ptr_nxt_c (tail_nxt)
    );

    assign count_nxt = tail_nxt - head_nxt;
    assign full_nxt  = (tail_nxt[PTR_W-1] != head_nxt[PTR_W-1]) &&
                       (tail_nxt[IDX_W-1:0] == head_nxt[IDX_W-1:0]);

    // Pending mask as it will stand after this edge, including the entry being written.
    always_comb begin
        logic [IDX_W-1:0] off;
        logic [REGNO-1:0] mask;
        pend_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off  = IDX_W'(i) - head_nxt[IDX_W-1:0];
            mask = (issue_acc && (IDX_W'(i) == tail[IDX_W-1:0])) ? i_issue_rf_ie : dest_q[i];
            if (PTR_W'(off) < count_nxt) begin
                pend_nxt = pend_nxt | mask;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
            end
            o_pending_mask <= '0;
            o_count        <= '0;
            o_full         <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            if (issue_acc) begin
                dest_q[tail[IDX_W-1:0]] <= i_issue_rf_ie;
            end
            o_pending_mask <= pend_nxt;
            o_count        <= count_nxt;
            o_full         <= full_nxt;
            o_err          <= o_err | err_set;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (REGNO=8, DEPTH=4).
module tb_hazard_scoreboard;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_issue;
    logic [7:0] i_issue_rf_ie;
    logic [7:0] i_issue_src;
    logic       o_issue_ok;
    logic       i_commit;
    logic       i_flush;
    logic       i_wb_valid;
    logic [7:0] o_pending_mask;
    logic [2:0] o_count;
    logic       o_full;
    logic       o_err;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_scoreboard #(.REGNO(8), .DEPTH(4)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_issue        (i_issue),
        .i_issue_rf_ie  (i_issue_rf_ie),
        .i_issue_src    (i_issue_src),
        .o_issue_ok     (o_issue_ok),
        .i_commit       (i_commit),
        .i_flush        (i_flush),
        .i_wb_valid     (i_wb_valid),
        .o_pending_mask (o_pending_mask),
        .o_count        (o_count),
        .o_full         (o_full),
        .o_err          (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        i_issue       = 1'b0;
        i_issue_rf_ie = '0;
        i_issue_src   = '0;
        i_commit      = 1'b0;
        i_flush       = 1'b0;
        i_wb_valid    = 1'b0;
    endtask

    // Clock edge, then sample registered outputs and release all inputs.
    task automatic tick();
        @(posedge i_clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [7:0] rf);
        i_issue = 1'b1;
        i_issue_rf_ie = rf;
        tick();
    endtask

    initial begin
        idle();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_pend", 32'(o_pending_mask), 32'h00);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        i_issue_src = 8'hff;
        #1;
        check("rst_ok", 32'(o_issue_ok), 32'd1);
        idle();

        // RAW on r2
        issue(8'h04);
        check("raw_count", 32'(o_count), 32'd1);
        check("raw_pend", 32'(o_pending_mask), 32'h04);
        i_issue_src = 8'h04;
        #1;
        check("raw_blocked", 32'(o_issue_ok), 32'd0);
        i_issue_src = 8'h08;
        #1;
        check("raw_indep_ok", 32'(o_issue_ok), 32'd1);
        i_issue_src = 8'h04;
        i_commit = 1'b1;
        #1;
        check("raw_commit_blocked", 32'(o_issue_ok), 32'd0);
        tick();
        i_issue_src = 8'h04;
        i_wb_valid = 1'b1;
        #1;
        check("raw_wb_release", 32'(o_issue_ok), 32'd1);
        tick();
        check("raw_empty", 32'(o_count), 32'd0);
        check("raw_err", 32'(o_err), 32'd0);

        // Fill with no-dest instructions
        for (int k = 0; k < 4; k++) issue(8'h00);
        check("full_count", 32'(o_count), 32'd4);
        check("full_flag", 32'(o_full), 32'd1);
        #1;
        check("full_blocked", 32'(o_issue_ok), 32'd0);
        i_commit = 1'b1; tick();
        i_commit = 1'b1; tick();
        i_wb_valid = 1'b1;
        #1;
        check("full_wb_frees", 32'(o_issue_ok), 32'd1);
        i_issue = 1'b1;
        i_issue_rf_ie = 8'h10;
        tick();
        check("full_swap_count", 32'(o_count), 32'd4);
        check("full_swap_flag", 32'(o_full), 32'd1);
        check("full_swap_pend", 32'(o_pending_mask), 32'h10);
        check("full_swap_err", 32'(o_err), 32'd0);
        i_flush = 1'b1; tick();
        check("full_flush_count", 32'(o_count), 32'd1);
        check("full_flush_pend", 32'(o_pending_mask), 32'h00);
        i_wb_valid = 1'b1; tick();
        check("full_drain", 32'(o_count), 32'd0);

        // Flush keeps committed r1 only
        issue(8'h02);
        issue(8'h04);
        issue(8'h08);
        i_commit = 1'b1; tick();
        i_flush = 1'b1; tick();
        check("flush_count", 32'(o_count), 32'd1);
        check("flush_pend", 32'(o_pending_mask), 32'h02);
        i_wb_valid = 1'b1; tick();
        check("flush_wb_count", 32'(o_count), 32'd0);
        check("flush_wb_pend", 32'(o_pending_mask), 32'h00);

        // Issue + commit + writeback in one cycle
        issue(8'h01);
        issue(8'h20);
        i_commit = 1'b1; tick();
        i_issue = 1'b1;
        i_issue_rf_ie = 8'h40;
        i_commit = 1'b1;
        i_wb_valid = 1'b1;
        tick();
        check("simul_count", 32'(o_count), 32'd2);
        check("simul_pend", 32'(o_pending_mask), 32'h60);
        check("simul_err", 32'(o_err), 32'd0);
        i_commit = 1'b1; tick();
        i_wb_valid = 1'b1; tick();
        i_wb_valid = 1'b1; tick();
        check("simul_drain", 32'(o_count), 32'd0);

        // Ten-cycle pipelined run across pointer wrap
        for (int k = 0; k < 10; k++) begin
            logic [7:0] exp_pend;
            i_issue = 1'b1;
            i_issue_rf_ie = 8'(1 << (k % 8));
            i_commit = (k >= 1);
            i_wb_valid = (k >= 2);
            tick();
            exp_pend = 8'(1 << (k % 8));
            if (k >= 1) exp_pend = exp_pend | 8'(1 << ((k - 1) % 8));
            check($sformatf("wrap_count_%0d", k), 32'(o_count), (k == 0) ? 32'd1 : 32'd2);
            check($sformatf("wrap_pend_%0d", k), 32'(o_pending_mask), 32'(exp_pend));
        end
        i_commit = 1'b1;
        i_wb_valid = 1'b1;
        tick();
        check("wrap_tail_count", 32'(o_count), 32'd1);
        check("wrap_tail_pend", 32'(o_pending_mask), 32'h02);
        i_wb_valid = 1'b1; tick();
        check("wrap_drain", 32'(o_count), 32'd0);
        check("wrap_err", 32'(o_err), 32'd0);

        // Protocol errors
        i_wb_valid = 1'b1; tick();
        check("wb_empty_err", 32'(o_err), 32'd1);
        check("wb_empty_count", 32'(o_count), 32'd0);
        issue(8'h01);
        i_issue = 1'b1;
        i_issue_rf_ie = 8'h02;
        i_issue_src = 8'h01;
        #1;
        check("reject_ok", 32'(o_issue_ok), 32'd0);
        tick();
        check("reject_count", 32'(o_count), 32'd1);
        check("reject_pend", 32'(o_pending_mask), 32'h01);

        // Asynchronous reset with entries in flight
        issue(8'h02);
        issue(8'h04);
        check("pre_rst_count", 32'(o_count), 32'd3);
        i_issue_src = 8'h07;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(o_count), 32'd0);
        check("mid_rst_pend", 32'(o_pending_mask), 32'h00);
        check("mid_rst_err", 32'(o_err), 32'd0);
        check("mid_rst_ok", 32'(o_issue_ok), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        check("post_rst_count", 32'(o_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
